// File: rtl/xintf_bus_bridge_if.sv
// DSP XINTF pad-side bundle: asynchronous strobes, address, and bidirectional data split into in/out/oe.
interface xintf_bus_bridge_if;
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 16;

    logic          i_xintf_cs_n;
    logic          i_xintf_rd_n;
    logic          i_xintf_we_n;
    logic [AW-1:0] i_xintf_addr;
    logic [DW-1:0] i_xintf_data_in;
    logic [DW-1:0] o_xintf_data_out;
    logic          o_xintf_data_oe;

    modport master (
        output i_xintf_cs_n, i_xintf_rd_n, i_xintf_we_n, i_xintf_addr, i_xintf_data_in,
        input  o_xintf_data_out, o_xintf_data_oe
    );

    modport slave (
        input  i_xintf_cs_n, i_xintf_rd_n, i_xintf_we_n, i_xintf_addr, i_xintf_data_in,
        output o_xintf_data_out, o_xintf_data_oe
    );
endinterface

// File: rtl/xintf_bus_bridge.sv
// Bridges asynchronous DSP XINTF accesses onto two dual-port BRAM port-B interfaces
// (PL-to-DSP read RAM, DSP-to-PL write RAM) with access counters and error pulses.
module xintf_bus_bridge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RAM_LAT     = 1,
    parameter int unsigned ADDR_MAX    = 63
) (
    input  logic              i_clk,
    input  logic              i_rst,
    xintf_bus_bridge_if.slave xif,
    output logic [8:0]        o_r_ram_addr,
    output logic              o_r_ram_ce,
    input  logic [15:0]       i_r_ram_dout,
    output logic [8:0]        o_w_ram_addr,
    output logic [15:0]       o_w_ram_din,
    output logic              o_w_ram_ce,
    output logic [15:0]       o_rd_cnt,
    output logic [15:0]       o_wr_cnt,
    output logic              o_addr_err,
    output logic              o_proto_err,
    output logic [2:0]        o_state
);
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;
    localparam int unsigned NS = SYNC_STAGES;
    localparam logic [1:0]  WAIT_LAST = 2'(RAM_LAT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_REQ    = 3'd1,
        RD_WAIT   = 3'd2,
        RD_HOLD   = 3'd3,
        WR_ACT    = 3'd4,
        WR_COMMIT = 3'd5,
        ERR_WAIT  = 3'd6
    } state_t;

    // Synchronizers: stage NS-1 is the synced copy, stage NS the previous-cycle copy.
    logic [NS-1:0] cs_q;
    logic [NS:0]   rd_q;
    logic [NS:0]   we_q;
    logic [NS:0]   vld_q;
    logic [AW-1:0] addr_q [NS+1];
    logic [DW-1:0] din_q  [NS+1];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cs_q  <= '1;
            rd_q  <= '1;
            we_q  <= '1;
            vld_q <= '0;
            for (int unsigned i = 0; i <= NS; i++) begin
                addr_q[i] <= '0;
                din_q[i]  <= '0;
            end
        end else begin
            cs_q      <= {cs_q[NS-2:0], xif.i_xintf_cs_n};
            rd_q      <= {rd_q[NS-1:0], xif.i_xintf_rd_n};
            we_q      <= {we_q[NS-1:0], xif.i_xintf_we_n};
            vld_q     <= {vld_q[NS-1:0], 1'b1};
            addr_q[0] <= xif.i_xintf_addr;
            din_q[0]  <= xif.i_xintf_data_in;
            for (int unsigned i = 1; i <= NS; i++) begin
                addr_q[i] <= addr_q[i-1];
                din_q[i]  <= din_q[i-1];
            end
        end
    end

    // Edges only count once the whole chain holds real pin samples, so a strobe
    // already low when reset releases never looks like a fresh falling edge.
    logic cs_s, rd_s, we_s, edge_ok, rd_fall, we_fall, we_rise;
    assign cs_s    = cs_q[NS-1];
    assign rd_s    = rd_q[NS-1];
    assign we_s    = we_q[NS-1];
    assign edge_ok = vld_q[NS];
    assign rd_fall = edge_ok &  rd_q[NS] & ~rd_s;
    assign we_fall = edge_ok &  we_q[NS] & ~we_s;
    assign we_rise = edge_ok & ~we_q[NS] &  we_s;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return 32'(a) <= ADDR_MAX;
    endfunction

    state_t        state_q, state_d;
    logic [AW-1:0] cap_addr_q, cap_addr_d;
    logic [DW-1:0] cap_data_q, cap_data_d;
    logic [1:0]    wait_q, wait_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          oe_q, oe_d;
    logic          r_ce_q, r_ce_d;
    logic [AW-1:0] r_addr_q, r_addr_d;
    logic          w_ce_q, w_ce_d;
    logic [AW-1:0] w_addr_q, w_addr_d;
    logic [DW-1:0] w_din_q, w_din_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic          addr_err_q, addr_err_d;
    logic          proto_err_q, proto_err_d;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            cap_addr_q  <= '0;
            cap_data_q  <= '0;
            wait_q      <= '0;
            data_out_q  <= '0;
            oe_q        <= 1'b0;
            r_ce_q      <= 1'b0;
            r_addr_q    <= '0;
            w_ce_q      <= 1'b0;
            w_addr_q    <= '0;
            w_din_q     <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            addr_err_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_addr_q  <= cap_addr_d;
            cap_data_q  <= cap_data_d;
            wait_q      <= wait_d;
            data_out_q  <= data_out_d;
            oe_q        <= oe_d;
            r_ce_q      <= r_ce_d;
            r_addr_q    <= r_addr_d;
            w_ce_q      <= w_ce_d;
            w_addr_q    <= w_addr_d;
            w_din_q     <= w_din_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            addr_err_q  <= addr_err_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Read CE is issued on entry to RD_REQ so RD_WAIT spans exactly RAM_LAT cycles.
    always_comb begin
        state_d     = state_q;
        cap_addr_d  = cap_addr_q;
        cap_data_d  = cap_data_q;
        wait_d      = '0;
        data_out_d  = '0;
        oe_d        = 1'b0;
        r_ce_d      = 1'b0;
        r_addr_d    = '0;
        w_ce_d      = 1'b0;
        w_addr_d    = '0;
        w_din_d     = '0;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        addr_err_d  = 1'b0;
        proto_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!cs_s && rd_fall && we_fall) begin
                    proto_err_d = 1'b1;
                    state_d     = ERR_WAIT;
                end else if (!cs_s && rd_fall) begin
                    cap_addr_d = addr_q[NS-1];
                    if (addr_ok(addr_q[NS-1])) begin
                        r_ce_d   = 1'b1;
                        r_addr_d = addr_q[NS-1];
                    end
                    state_d = RD_REQ;
                end else if (!cs_s && we_fall) begin
                    state_d = WR_ACT;
                end
            end
            RD_REQ: begin
                if (cs_s) begin
                    state_d = IDLE;
                end else if (addr_ok(cap_addr_q)) begin
                    state_d = RD_WAIT;
                end else begin
                    addr_err_d = 1'b1;
                    oe_d       = 1'b1;
                    state_d    = RD_HOLD;
                end
            end
            RD_WAIT: begin
                if (cs_s) begin
                    state_d = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    data_out_d = i_r_ram_dout;
                    oe_d       = 1'b1;
                    state_d    = RD_HOLD;
                end else begin
                    wait_d = 2'(wait_q + 2'd1);
                end
            end
            RD_HOLD: begin
                // A completed strobe wins over a simultaneous chip-select release.
                if (rd_s) begin
                    rd_cnt_d = CW'(rd_cnt_q + 1'b1);
                    state_d  = IDLE;
                end else if (cs_s) begin
                    state_d = IDLE;
                end else begin
                    data_out_d = data_out_q;
                    oe_d       = oe_q;
                end
            end
            WR_ACT: begin
                if (cs_s) begin
                    state_d = IDLE;
                end else if (we_rise) begin
                    cap_addr_d = addr_q[NS];
                    cap_data_d = din_q[NS];
                    state_d    = WR_COMMIT;
                end
            end
            WR_COMMIT: begin
                if (addr_ok(cap_addr_q)) begin
                    w_ce_d   = 1'b1;
                    w_addr_d = cap_addr_q;
                    w_din_d  = cap_data_q;
                    wr_cnt_d = CW'(wr_cnt_q + 1'b1);
                end else begin
                    addr_err_d = 1'b1;
                end
                state_d = IDLE;
            end
            ERR_WAIT: begin
                if (rd_s && we_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign xif.o_xintf_data_out = data_out_q;
    assign xif.o_xintf_data_oe  = oe_q;
    assign o_r_ram_addr         = r_addr_q;
    assign o_r_ram_ce           = r_ce_q;
    assign o_w_ram_addr         = w_addr_q;
    assign o_w_ram_din          = w_din_q;
    assign o_w_ram_ce           = w_ce_q;
    assign o_rd_cnt             = rd_cnt_q;
    assign o_wr_cnt             = wr_cnt_q;
    assign o_addr_err           = addr_err_q;
    assign o_proto_err          = proto_err_q;
    assign o_state              = state_q;
endmodule

// File: tb/tb_xintf_bus_bridge.sv
// Directed + randomized bench for xintf_bus_bridge against a transaction-level expectation model.
module tb_xintf_bus_bridge;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned RAM_LAT     = 1;
    localparam int unsigned ADDR_MAX    = 63;
    localparam int unsigned RD_LAT      = SYNC_STAGES + 2 + RAM_LAT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xintf_bus_bridge_if xif ();

    logic [8:0]  r_ram_addr, w_ram_addr;
    logic        r_ram_ce, w_ram_ce;
    logic [15:0] r_ram_dout = 16'h0000;
    logic [15:0] w_ram_din, rd_cnt, wr_cnt;
    logic        addr_err, proto_err;
    logic [2:0]  state;

    xintf_bus_bridge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RAM_LAT     (RAM_LAT),
        .ADDR_MAX    (ADDR_MAX)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .xif          (xif),
        .o_r_ram_addr (r_ram_addr),
        .o_r_ram_ce   (r_ram_ce),
        .i_r_ram_dout (r_ram_dout),
        .o_w_ram_addr (w_ram_addr),
        .o_w_ram_din  (w_ram_din),
        .o_w_ram_ce   (w_ram_ce),
        .o_rd_cnt     (rd_cnt),
        .o_wr_cnt     (wr_cnt),
        .o_addr_err   (addr_err),
        .o_proto_err  (proto_err),
        .o_state      (state)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Read-side RAM with one-cycle latency; contents owned by the bench.
    logic [15:0] rmem [512];
    always @(posedge clk) if (r_ram_ce) r_ram_dout <= rmem[r_ram_addr];

    // Observed side effects, sampled mid-cycle.
    int          n_rce = 0, n_wce = 0, n_aerr = 0, n_perr = 0;
    logic [8:0]  last_raddr = '0, last_waddr = '0;
    logic [15:0] last_wdin = '0;
    logic [15:0] obs_wmem [512];
    logic [15:0] exp_wmem [512];
    logic [15:0] exp_rd_cnt = '0, exp_wr_cnt = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ce_exclusive", 32'(r_ram_ce & w_ram_ce), 32'd0);
            if (!r_ram_ce) chk("r_addr_idle_zero", 32'(r_ram_addr), 32'd0);
            if (!w_ram_ce) chk("w_bus_idle_zero", {7'd0, w_ram_addr, w_ram_din}, 32'd0);
            if (r_ram_ce) begin n_rce++; last_raddr = r_ram_addr; end
            if (w_ram_ce) begin
                n_wce++;
                last_waddr = w_ram_addr;
                last_wdin  = w_ram_din;
                obs_wmem[w_ram_addr] = w_ram_din;
            end
            if (addr_err)  n_aerr++;
            if (proto_err) n_perr++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram"}, {13'd0, r_ram_ce, w_ram_ce, r_ram_addr, w_ram_addr}, 32'd0);
        chk({tag, "_wdin"}, 32'(w_ram_din), 32'd0);
        chk({tag, "_cnts"}, {rd_cnt, wr_cnt}, 32'd0);
        chk({tag, "_flags"}, {27'd0, addr_err, proto_err, state}, 32'd0);
        chk({tag, "_pad"}, {15'd0, xif.o_xintf_data_oe, xif.o_xintf_data_out}, 32'd0);
    endtask

    task automatic do_read(input logic [8:0] a);
        int          s_rce, s_aerr, lat;
        logic        ok;
        logic [15:0] exp_d;
        ok     = (32'(a) <= ADDR_MAX);
        exp_d  = ok ? rmem[a] : 16'h0000;
        s_rce  = n_rce;
        s_aerr = n_aerr;
        xif.i_xintf_cs_n = 1'b0;
        xif.i_xintf_addr = a;
        cyc(1);
        xif.i_xintf_rd_n = 1'b0;
        lat = 0;
        while (xif.o_xintf_data_oe !== 1'b1 && lat < 40) begin
            cyc(1);
            lat++;
        end
        chk("rd_oe_rise", 32'(xif.o_xintf_data_oe), 32'd1);
        if (ok) chk("rd_latency", 32'(lat), 32'(RD_LAT));
        chk("rd_data", 32'(xif.o_xintf_data_out), 32'(exp_d));
        cyc(3);
        chk("rd_hold", {15'd0, xif.o_xintf_data_oe, xif.o_xintf_data_out}, {15'd0, 1'b1, exp_d});
        chk("rd_ce_count", 32'(n_rce - s_rce), 32'(ok));
        if (ok) chk("rd_ce_addr", 32'(last_raddr), 32'(a));
        chk("rd_addr_err", 32'(n_aerr - s_aerr), 32'(!ok));
        xif.i_xintf_rd_n = 1'b1;
        cyc(SYNC_STAGES + 2);
        chk("rd_oe_fall", 32'(xif.o_xintf_data_oe), 32'd0);
        exp_rd_cnt = exp_rd_cnt + 16'd1;
        chk("rd_cnt", 32'(rd_cnt), 32'(exp_rd_cnt));
        chk("rd_end_idle", 32'(state), 32'd0);
        xif.i_xintf_cs_n = 1'b1;
        cyc(3);
    endtask

    task automatic do_write(input logic [8:0] a, input logic [15:0] d);
        int   s_wce, s_aerr;
        logic ok;
        ok     = (32'(a) <= ADDR_MAX);
        s_wce  = n_wce;
        s_aerr = n_aerr;
        xif.i_xintf_cs_n    = 1'b0;
        xif.i_xintf_addr    = a;
        xif.i_xintf_data_in = d;
        cyc(1);
        xif.i_xintf_we_n = 1'b0;
        cyc(4);
        // Bus changes together with the rising strobe; the value held while low must be written.
        xif.i_xintf_we_n    = 1'b1;
        xif.i_xintf_addr    = ~a;
        xif.i_xintf_data_in = ~d;
        cyc(SYNC_STAGES + 4);
        chk("wr_ce_count", 32'(n_wce - s_wce), 32'(ok));
        if (ok) begin
            chk("wr_addr", 32'(last_waddr), 32'(a));
            chk("wr_din", 32'(last_wdin), 32'(d));
            exp_wr_cnt  = exp_wr_cnt + 16'd1;
            exp_wmem[a] = d;
        end
        chk("wr_addr_err", 32'(n_aerr - s_aerr), 32'(!ok));
        chk("wr_cnt", 32'(wr_cnt), 32'(exp_wr_cnt));
        chk("wr_end_idle", 32'(state), 32'd0);
        xif.i_xintf_cs_n = 1'b1;
        cyc(2);
    endtask

    initial begin : main
        int s_rce, s_wce, s_perr;
        for (int i = 0; i < 512; i++) begin
            rmem[i]     = 16'($urandom);
            obs_wmem[i] = 16'h0000;
            exp_wmem[i] = 16'h0000;
        end
        rmem[5] = 16'hA55A;
        xif.i_xintf_cs_n    = 1'b1;
        xif.i_xintf_rd_n    = 1'b1;
        xif.i_xintf_we_n    = 1'b1;
        xif.i_xintf_addr    = '0;
        xif.i_xintf_data_in = '0;

        cyc(2);
        chk_all_zero("reset");
        rst_n = 1'b1;
        cyc(4);

        do_read(9'd5);
        do_write(9'd12, 16'h1234);
        do_read(9'd100);
        do_write(9'd100, 16'hBEEF);
        do_read(9'(ADDR_MAX));
        do_read(9'(ADDR_MAX + 1));
        do_write(9'(ADDR_MAX), 16'h0F0F);
        do_write(9'(ADDR_MAX + 1), 16'hF0F0);

        // Simultaneous read and write strobes.
        s_rce = n_rce; s_wce = n_wce; s_perr = n_perr;
        xif.i_xintf_cs_n = 1'b0;
        cyc(1);
        xif.i_xintf_rd_n = 1'b0;
        xif.i_xintf_we_n = 1'b0;
        cyc(SYNC_STAGES + 3);
        chk("proto_pulse", 32'(n_perr - s_perr), 32'd1);
        chk("proto_state", 32'(state), 32'd6);
        xif.i_xintf_rd_n = 1'b1;
        cyc(SYNC_STAGES + 3);
        chk("proto_hold", 32'(state), 32'd6);
        xif.i_xintf_we_n = 1'b1;
        cyc(SYNC_STAGES + 3);
        chk("proto_exit", 32'(state), 32'd0);
        chk("proto_no_ce", 32'((n_rce - s_rce) + (n_wce - s_wce)), 32'd0);
        xif.i_xintf_cs_n = 1'b1;
        cyc(2);

        // Chip select dropped mid-write.
        s_wce = n_wce;
        xif.i_xintf_cs_n = 1'b0;
        xif.i_xintf_addr = 9'd20;
        xif.i_xintf_data_in = 16'h5555;
        cyc(1);
        xif.i_xintf_we_n = 1'b0;
        cyc(5);
        chk("wabort_active", 32'(state), 32'd4);
        xif.i_xintf_cs_n = 1'b1;
        cyc(SYNC_STAGES + 3);
        chk("wabort_idle", 32'(state), 32'd0);
        xif.i_xintf_we_n = 1'b1;
        cyc(SYNC_STAGES + 3);
        chk("wabort_no_ce", 32'(n_wce - s_wce), 32'd0);
        chk("wabort_cnt", 32'(wr_cnt), 32'(exp_wr_cnt));

        // Chip select dropped while read data is held.
        xif.i_xintf_cs_n = 1'b0;
        xif.i_xintf_addr = 9'd7;
        cyc(1);
        xif.i_xintf_rd_n = 1'b0;
        cyc(RD_LAT + 2);
        chk("rabort_oe", 32'(xif.o_xintf_data_oe), 32'd1);
        xif.i_xintf_cs_n = 1'b1;
        cyc(SYNC_STAGES + 2);
        chk("rabort_oe_off", 32'(xif.o_xintf_data_oe), 32'd0);
        chk("rabort_cnt", 32'(rd_cnt), 32'(exp_rd_cnt));
        xif.i_xintf_rd_n = 1'b1;
        cyc(4);

        for (int k = 0; k < 16; k++) begin
            logic [8:0] a;
            a = 9'($urandom_range(0, 90));
            if ($urandom_range(0, 1) == 0) do_read(a);
            else do_write(a, 16'($urandom));
        end

        for (int a = 0; a <= int'(ADDR_MAX); a++)
            chk("wmem_contents", 32'(obs_wmem[a]), 32'(exp_wmem[a]));

        // Reset during held read data, strobe kept low through release.
        xif.i_xintf_cs_n = 1'b0;
        xif.i_xintf_addr = 9'd7;
        cyc(1);
        xif.i_xintf_rd_n = 1'b0;
        cyc(RD_LAT + 2);
        chk("rst_rd_oe_before", 32'(xif.o_xintf_data_oe), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        exp_rd_cnt = '0;
        exp_wr_cnt = '0;
        cyc(2);
        rst_n = 1'b1;
        s_rce = n_rce;
        cyc(10);
        chk("rst_stuck_rd_no_ce", 32'(n_rce - s_rce), 32'd0);
        chk("rst_stuck_rd_idle", {28'd0, xif.o_xintf_data_oe, state}, 32'd0);
        xif.i_xintf_rd_n = 1'b1;
        cyc(4);
        xif.i_xintf_cs_n = 1'b1;
        cyc(2);
        do_read(9'd7);

        // Reset while a write strobe is active.
        s_wce = n_wce;
        xif.i_xintf_cs_n = 1'b0;
        xif.i_xintf_addr = 9'd30;
        xif.i_xintf_data_in = 16'h7777;
        cyc(1);
        xif.i_xintf_we_n = 1'b0;
        cyc(5);
        chk("rst_wr_active", 32'(state), 32'd4);
        rst_n = 1'b0;
        xif.i_xintf_we_n = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(SYNC_STAGES + 5);
        chk("rst_wr_no_ce", 32'(n_wce - s_wce), 32'd0);
        chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        xif.i_xintf_cs_n = 1'b1;
        cyc(2);
        do_write(9'd31, 16'hC0DE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/xintf_bus_bridge.md
XINTF_BUS_BRIDGE -- requirements
Module: xintf_bus_bridge

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, flops per synchronizer on async XINTF strobes/bus (min 2).
REQ-002 SHALL have parameter RAM_LAT, default 1, DPBRAM read latency in i_clk cycles (1..3).
REQ-003 SHALL have parameter ADDR_MAX, default 63, highest valid XINTF word address.
REQ-004 SHALL have ports: i_clk  in  1  system clock; i_rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: i_xintf_cs_n  in  1  DSP zone chip select; i_xintf_rd_n  in  1  read strobe; i_xintf_we_n  in  1  write strobe.
REQ-006 SHALL have ports: i_xintf_addr  in  9  word address; i_xintf_data_in  in  16  DSP write data.
REQ-007 SHALL have ports: o_xintf_data_out  out  16  read data to pad; o_xintf_data_oe  out  1  pad output enable.
REQ-008 SHALL have ports: o_r_ram_addr  out  9; o_r_ram_ce  out  1; i_r_ram_dout  in  16  (PL-to-DSP DPBRAM, port B read).
REQ-009 SHALL have ports: o_w_ram_addr  out  9; o_w_ram_din  out  16; o_w_ram_ce  out  1  (DSP-to-PL DPBRAM, port B write).
REQ-010 SHALL have ports: o_rd_cnt  out  16; o_wr_cnt  out  16  completed-access counters; o_addr_err  out  1; o_proto_err  out  1  one-cycle pulses; o_state  out  3  debug.

Function
REQ-011 SHALL pass cs_n, rd_n, we_n, addr, data_in through SYNC_STAGES flops, all aligned; edges detected on synchronized copies only.
REQ-012 SHALL implement FSM IDLE(0), RD_REQ(1), RD_WAIT(2), RD_HOLD(3), WR_ACT(4), WR_COMMIT(5), ERR_WAIT(6); o_state = encoding.
REQ-013 IDLE: cs low and rd falling edge -> RD_REQ, capturing synced addr; cs low and we falling edge -> WR_ACT.
REQ-014 IDLE: rd and we falling in same cycle -> o_proto_err pulse, ERR_WAIT, no RAM access.
REQ-015 RD_REQ: valid addr -> o_r_ram_addr=addr, o_r_ram_ce=1 exactly one cycle, then RD_WAIT; invalid addr (>ADDR_MAX) -> no ce, o_addr_err pulse, data 16'h0000, go RD_HOLD.
REQ-016 RD_WAIT: remain RAM_LAT cycles, then latch i_r_ram_dout into o_xintf_data_out, set o_xintf_data_oe=1, go RD_HOLD.
REQ-017 RD_HOLD: hold data/oe until synced rd_n or cs_n high; then oe=0 same cycle as exit, o_rd_cnt+1, IDLE.
REQ-018 WR_ACT: on synced we rising edge with cs still low -> capture addr/data from sync stage of previous cycle, go WR_COMMIT.
REQ-019 WR_COMMIT: valid addr -> o_w_ram_ce=1 one cycle with o_w_ram_addr/din, o_wr_cnt+1; invalid -> no ce, o_addr_err pulse; then IDLE.
REQ-020 cs_n rising in RD_REQ/RD_WAIT/RD_HOLD/WR_ACT -> abort to IDLE, oe=0, no write, no counter change.
REQ-021 ERR_WAIT: stay until synced rd_n, we_n both high, then IDLE.
REQ-022 o_w_ram_ce, o_r_ram_ce SHALL never be high in same cycle; RAM addr/din outputs 0 when ce low.
REQ-023 Counters 16-bit unsigned, wrap 16'hFFFF -> 16'h0000.
REQ-024 Read-to-data latency from rd_n pin fall: SYNC_STAGES+2+RAM_LAT cycles.

Reset
REQ-025 i_rst low SHALL asynchronously force FSM IDLE, all sync flops to idle level (strobes 1, bus 0), all outputs 0, counters 0.
REQ-026 Reset mid-read SHALL drop o_xintf_data_oe immediately; mid-write SHALL suppress commit.
REQ-027 After release, first transaction SHALL require a fresh falling edge (strobe already low at release is ignored until high).

Verification
REQ-028 Read addr 5, RAM[5]=16'hA55A, RAM_LAT=1 -> ce one cycle addr 5, oe=1, data 16'hA55A 5 cycles after rd fall; o_rd_cnt=1 after rd rise.
REQ-029 Write addr 12 data 16'h1234 -> single ce cycle, addr 12, din 16'h1234 after we rise; o_wr_cnt=1.
REQ-030 Read addr 100 -> no ce, o_addr_err pulse, data 16'h0000 with oe=1; write addr 100 -> no ce, o_addr_err pulse.
REQ-031 rd and we fall together -> o_proto_err pulse, no ce, FSM 6 until both high, then IDLE.
REQ-032 cs_n rises during WR_ACT -> no write, o_wr_cnt unchanged; 65536 writes -> o_wr_cnt=0.
REQ-033 i_rst asserted during RD_HOLD -> oe 0 same instant; rd held low through release -> no read until rd toggles.
